alu_sequencer: RTL and testbench
================================

# alu_sequencer

Program sequencer that sits directly upstream of the accumulator ALU. It holds a small writable program of {opcode, operand} words and, on `start`, issues one word per clock onto the ALU's `opcode`/`data_in` inputs. It captures the ALU's `data_out` whenever an ALU_OUT instruction completes, and reports completion with a start/busy/done handshake. Driving stimulus from the sequencer replaces hand-timed opcode sequences and gives the board a repeatable self-running ALU program.

## Interface

Parameters:
- `DATA_WIDTH`, 8, operand and result width; must match the ALU.
- `ADDR_WIDTH`, 4, program address width; program depth is 2^ADDR_WIDTH words.
- `OUT_LATENCY`, 1, clocks from the ALU sampling ALU_OUT to `data_out` being valid.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program write enable.
- `prog_addr`  in  ADDR_WIDTH  program write address.
- `prog_wdata`  in  DATA_WIDTH+4  program word, laid out as {opcode[3:0], operand[DATA_WIDTH-1:0]}.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high from the accepted start until done.
- `done`  out  1  one-cycle pulse at run end.
- `pc`  out  ADDR_WIDTH  address of the next word to fetch.
- `alu_opcode`  out  4  to the ALU `opcode` input (registered).
- `alu_data_in`  out  DATA_WIDTH  to the ALU `data_in` input (registered).
- `alu_data_out`  in  DATA_WIDTH  from the ALU `data_out` output.
- `result`  out  DATA_WIDTH  last captured ALU output.
- `result_valid`  out  1  one-cycle pulse when `result` updates.

## Operation

- **Program memory**
  - 2^ADDR_WIDTH x (DATA_WIDTH+4) array, asynchronous read, not reset; contents survive reset.
  - Writes occur only when `prog_we` is high and the state is IDLE.
  - `prog_we` is ignored while `busy` is high.
- **Opcodes**
  - 4'h1–4'h8 are ALU opcodes (REGA, ADD, SUB, AND, OR, XOR, OUT, RESET) and are issued unchanged.
  - 4'h0 is NOP: issued as 4'h0.
  - 4'hF is HALT: sequencer-only, never issued; the sequencer drives 4'h0 in its place.
  - 4'h9–4'hE are passed through unchanged.
- **State machine: IDLE, RUN, DRAIN**
  - IDLE: `alu_opcode` = 0, `alu_data_in` = 0, `pc` = 0. If `start` = 1, go to RUN and set `busy` = 1.
  - RUN, each edge:
    - If mem[pc] is HALT: drive opcode 0, go to DRAIN.
    - Otherwise: register mem[pc] onto `alu_opcode`/`alu_data_in`.
      - If `pc` is the last address (all ones), go to DRAIN with no wrap.
      - Else increment `pc`.
  - DRAIN: drive `alu_opcode` = 0 for exactly OUT_LATENCY+1 cycles. Then pulse `done`, clear `busy`, clear `pc`, and return to IDLE.
- **Result capture**
  - A shift register of length OUT_LATENCY+1 tracks each issued ALU_OUT (4'h7).
  - When a tracked entry exits the shift register, `result` <= `alu_data_out` and `result_valid` pulses.
  - `result` holds its value between captures and across runs.
- **Boundary conditions**
  - `start` while busy: ignored.
  - `start` and `prog_we` in the same IDLE cycle: the write completes, and the run fetches the new contents, including address 0.
  - Word 0 = HALT: no ALU operations are issued; `done` follows the drain.
  - `reset` mid-run: after the edge the state is IDLE and every output is 0. Pending captures are discarded and produce no `result_valid`. Memory is unchanged.

## Timing

- **Reset values:** `busy`, `done`, `pc`, `alu_opcode`, `alu_data_in`, `result`, `result_valid` all 0.
- **Issue timing:** `start` is sampled at edge E0. Word k appears on the ALU pins after edge E(k+1) and is held for one cycle. The ALU samples it at E(k+2).
- **Capture timing:** an ALU_OUT driven at edge Ei is captured at E(i+OUT_LATENCY+1). `result_valid` is high during the following cycle.
- **HALT at index h:** HALT is fetched at E(h+1) and DRAIN is entered. `done` = 1 and `busy` = 0 after E(h+OUT_LATENCY+2).
- **Full program without HALT:** the last word is issued at E(2^ADDR_WIDTH). `done` follows after another OUT_LATENCY+2 edges.
- **Throughput:** one instruction per clock; no stalls.

## Test plan

1. **Reset values.** Assert `reset` for 2 cycles -> all outputs are 0. Release, then pulse `start` with word 0 = HALT -> `busy` is high for 3 cycles, then a `done` pulse; `alu_opcode` stays 0 throughout.
2. **Pipeline timing (bench stub drives `alu_data_out` = 8'h5A).** Program REGA 0x0F, OUT, HALT; start at E0 -> opcode 1 / data 0x0F after E1; opcode 7 after E2; `result` = 0x5A with `result_valid` after E4; `done` after E5.
3. **Integrated with the real ALU.** Program RESET, REGA 0x0F, ADD, REGA 0xAA, AND, REGA 0x05, OR, REGA 0x0F, SUB, OUT, HALT -> exactly one `result_valid` pulse, `result` = 0x00, `done` 3 cycles after the HALT fetch.
4. **Full program, no HALT.** 16 NOP words with OUT at address 15 -> `pc` counts 0..15 with no wrap; capture after E18; `done` after E19.
5. **Handshake guards.** Pulse `start` and `prog_we` mid-run -> the run timing is unchanged and the memory readback is unchanged. Pulse `start` and `prog_we` (addr 0 = OUT) in the same IDLE cycle -> OUT is issued first.
6. **Reset mid-run.** Assert `reset` one cycle after an OUT is issued -> no `result_valid`, all outputs 0. A rerun without reprogramming reproduces the original program.

Source files
------------

// File: rtl/alu_sequencer.sv
// Program sequencer feeding the accumulator ALU: stores {opcode, operand} words,
// issues one per clock on start, and captures ALU_OUT results with a fixed latency.
module alu_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int OUT_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    prog_we_i,
    input  logic [ADDR_WIDTH-1:0]   prog_addr_i,
    input  logic [DATA_WIDTH+3:0]   prog_wdata_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic [3:0]              alu_opcode_o,
    output logic [DATA_WIDTH-1:0]   alu_data_in_o,
    input  logic [DATA_WIDTH-1:0]   alu_data_out_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic                    result_valid_o
);

    localparam int         WORD_W  = DATA_WIDTH + 4;
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam int         CNT_W   = $clog2(OUT_LATENCY + 2);
    localparam int         TRK_W   = OUT_LATENCY + 1;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(OUT_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [WORD_W-1:0]     mem [DEPTH];
    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [3:0]            opcode_q;
    logic [DATA_WIDTH-1:0] data_in_q;
    logic [CNT_W-1:0]      drain_cnt_q;
    logic [TRK_W-1:0]      trk_q;
    logic [TRK_W-1:0]      trk_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  result_valid_q;

    logic [WORD_W-1:0]     fetch_word;
    logic [3:0]            fetch_op;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  out_issue;

    assign fetch_word = mem[pc_q];
    assign fetch_op   = fetch_word[WORD_W-1 -: 4];
    assign fetch_data = fetch_word[DATA_WIDTH-1:0];
    assign out_issue  = (state_q == RUN) && (fetch_op == OP_OUT);

    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state_q == IDLE)) begin
            mem[prog_addr_i] <= prog_wdata_i;
        end
    end

    // Drain ends one edge after the last possible capture: a HALT fetch already
    // spent one of those cycles, a run ending on the last address has not.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pc_q        <= '0;
            opcode_q    <= '0;
            data_in_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    opcode_q  <= '0;
                    data_in_q <= '0;
                    pc_q      <= '0;
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (fetch_op == OP_HALT) begin
                        opcode_q    <= '0;
                        data_in_q   <= '0;
                        state_q     <= DRAIN;
                        drain_cnt_q <= CNT_W'(1);
                    end else begin
                        opcode_q  <= fetch_op;
                        data_in_q <= fetch_data;
                        if (pc_q == '1) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= '0;
                        end else begin
                            pc_q <= pc_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    opcode_q  <= '0;
                    data_in_q <= '0;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        pc_q        <= '0;
                        drain_cnt_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Each issued ALU_OUT rides this shift register until the ALU result is valid.
    always_comb begin
        trk_d = (trk_q << 1) | TRK_W'(out_issue);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            trk_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            trk_q          <= trk_d;
            result_valid_q <= trk_q[OUT_LATENCY];
            if (trk_q[OUT_LATENCY]) begin
                result_q <= alu_data_out_i;
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pc_o           = pc_q;
    assign alu_opcode_o   = opcode_q;
    assign alu_data_in_o  = data_in_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: handshake timing, result capture, guards,
// mid-run reset, and a run driving a behavioural accumulator ALU.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        progWe = 1'b0;
    logic [3:0]  progAddr = '0;
    logic [11:0] progWdata = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [3:0]  aluOpcode;
    logic [7:0]  aluDataIn;
    logic [7:0]  aluDataOut;
    logic [7:0]  result;
    logic        resultValid;

    logic        useAlu = 1'b0;
    logic [7:0]  stubOut = '0;
    logic [7:0]  aluA = '0;
    logic [7:0]  aluAcc = '0;
    logic [7:0]  aluOut = '0;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_LATENCY(1)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .prog_we_i      (progWe),
        .prog_addr_i    (progAddr),
        .prog_wdata_i   (progWdata),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .pc_o           (pc),
        .alu_opcode_o   (aluOpcode),
        .alu_data_in_o  (aluDataIn),
        .alu_data_out_i (aluDataOut),
        .result_o       (result),
        .result_valid_o (resultValid)
    );

    always #5 clk = ~clk;

    // Behavioural accumulator ALU: REGA loads A, arithmetic ops combine acc with A,
    // OUT presents acc one clock after sampling.
    always @(posedge clk) begin
        case (aluOpcode)
            4'h1: aluA   <= aluDataIn;
            4'h2: aluAcc <= aluAcc + aluA;
            4'h3: aluAcc <= aluAcc - aluA;
            4'h4: aluAcc <= aluAcc & aluA;
            4'h5: aluAcc <= aluAcc | aluA;
            4'h6: aluAcc <= aluAcc ^ aluA;
            4'h7: aluOut <= aluAcc;
            4'h8: aluAcc <= 8'h00;
            default: ;
        endcase
    end

    assign aluDataOut = useAlu ? aluOut : stubOut;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [3:0] addr, input logic [11:0] data);
        progWe    = 1'b1;
        progAddr  = addr;
        progWdata = data;
        tick();
        progWe    = 1'b0;
    endtask

    task automatic pulseStart;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, pc, aluOpcode, aluDataIn, result, resultValid} !== 27'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got busy=%0d done=%0d pc=%0d op=%h din=%h res=%h rv=%0d exp all 0",
                     busy, done, pc, aluOpcode, aluDataIn, result, resultValid);
        end
        reset = 1'b0;
        writeWord(4'd0, 12'hF00);
        pulseStart();
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) tick();
            checks++;
            if (busy !== (c < 3) || done !== (c == 3) || aluOpcode !== 4'h0) begin
                errors++;
                $display("[TB] FAIL halt_first E%0d got busy=%0d done=%0d op=%h exp busy=%0d done=%0d op=0",
                         c, busy, done, aluOpcode, (c < 3), (c == 3));
            end
        end
    endtask

    task automatic test_pipeline;
        logic [3:0] expOp;
        logic [7:0] expDin;
        useAlu  = 1'b0;
        stubOut = 8'h5A;
        writeWord(4'd0, 12'h10F);
        writeWord(4'd1, 12'h700);
        writeWord(4'd2, 12'hF00);
        pulseStart();
        for (int c = 1; c <= 5; c++) begin
            tick();
            expOp  = (c == 1) ? 4'h1 : (c == 2) ? 4'h7 : 4'h0;
            expDin = (c == 1) ? 8'h0F : 8'h00;
            checks++;
            if (aluOpcode !== expOp || aluDataIn !== expDin) begin
                errors++;
                $display("[TB] FAIL pipe_issue E%0d got op=%h din=%h exp op=%h din=%h",
                         c, aluOpcode, aluDataIn, expOp, expDin);
            end
            checks++;
            if (resultValid !== (c == 4) || done !== (c == 5) || busy !== (c < 5)) begin
                errors++;
                $display("[TB] FAIL pipe_ctrl E%0d got rv=%0d done=%0d busy=%0d exp rv=%0d done=%0d busy=%0d",
                         c, resultValid, done, busy, (c == 4), (c == 5), (c < 5));
            end
        end
        checks++;
        if (result !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL pipe_result got %h exp 5a", result);
        end
    endtask

    task automatic test_alu_program;
        logic [11:0] prog [11] = '{12'h800, 12'h10F, 12'h200, 12'h1AA, 12'h400, 12'h105,
                                   12'h500, 12'h10F, 12'h300, 12'h700, 12'hF00};
        int rvCount = 0;
        int rvCycle = -1;
        int doneCycle = -1;
        useAlu = 1'b1;
        for (int i = 0; i < 11; i++) writeWord(4'(i), prog[i]);
        pulseStart();
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (resultValid === 1'b1) begin
                rvCount++;
                rvCycle = c;
            end
            if (done === 1'b1 && doneCycle < 0) doneCycle = c;
        end
        checks++;
        if (rvCount != 1 || rvCycle != 12) begin
            errors++;
            $display("[TB] FAIL alu_capture got count=%0d at E%0d exp count=1 at E12", rvCount, rvCycle);
        end
        checks++;
        if (result !== 8'h00) begin
            errors++;
            $display("[TB] FAIL alu_result got %h exp 00", result);
        end
        checks++;
        if (doneCycle != 13 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_done got E%0d busy=%0d exp E13 busy=0", doneCycle, busy);
        end
        useAlu = 1'b0;
    endtask

    task automatic test_full_program;
        logic [3:0] expPc;
        stubOut = 8'h3C;
        for (int i = 0; i < 15; i++) writeWord(4'(i), 12'h000);
        writeWord(4'd15, 12'h700);
        pulseStart();
        checks++;
        if (pc !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_start got pc=%0d busy=%0d exp pc=0 busy=1", pc, busy);
        end
        for (int c = 1; c <= 19; c++) begin
            tick();
            expPc = (c <= 15) ? 4'(c) : (c <= 18) ? 4'd15 : 4'd0;
            checks++;
            if (pc !== expPc || aluOpcode !== ((c == 16) ? 4'h7 : 4'h0)) begin
                errors++;
                $display("[TB] FAIL full_pc E%0d got pc=%0d op=%h exp pc=%0d op=%h",
                         c, pc, aluOpcode, expPc, (c == 16) ? 4'h7 : 4'h0);
            end
            checks++;
            if (resultValid !== (c == 18) || done !== (c == 19) || busy !== (c < 19)) begin
                errors++;
                $display("[TB] FAIL full_ctrl E%0d got rv=%0d done=%0d busy=%0d exp rv=%0d done=%0d busy=%0d",
                         c, resultValid, done, busy, (c == 18), (c == 19), (c < 19));
            end
        end
        checks++;
        if (result !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL full_result got %h exp 3c", result);
        end
    endtask

    task automatic test_handshake_guards;
        int doneCycle;
        stubOut = 8'h44;
        writeWord(4'd0, 12'h111);
        writeWord(4'd1, 12'h700);
        writeWord(4'd2, 12'hF00);
        for (int pass = 0; pass < 2; pass++) begin
            doneCycle = -1;
            pulseStart();
            for (int c = 1; c <= 7; c++) begin
                if (pass == 0 && c == 2) begin
                    start     = 1'b1;
                    progWe    = 1'b1;
                    progAddr  = 4'd2;
                    progWdata = 12'h000;
                end
                tick();
                start  = 1'b0;
                progWe = 1'b0;
                if (done === 1'b1 && doneCycle < 0) doneCycle = c;
                if (c == 3) begin
                    checks++;
                    if (aluOpcode !== 4'h0 || pc !== 4'd2) begin
                        errors++;
                        $display("[TB] FAIL guard_halt pass%0d got op=%h pc=%0d exp op=0 pc=2",
                                 pass, aluOpcode, pc);
                    end
                end
            end
            checks++;
            if (doneCycle != 5 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL guard_done pass%0d got E%0d busy=%0d exp E5 busy=0",
                         pass, doneCycle, busy);
            end
        end
    endtask

    task automatic test_start_with_write;
        stubOut   = 8'h66;
        progWe    = 1'b1;
        progAddr  = 4'd0;
        progWdata = 12'h700;
        start     = 1'b1;
        tick();
        progWe    = 1'b0;
        start     = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (aluOpcode !== ((c <= 2) ? 4'h7 : 4'h0) || resultValid !== (c == 3 || c == 4) ||
                done !== (c == 5)) begin
                errors++;
                $display("[TB] FAIL same_cycle E%0d got op=%h rv=%0d done=%0d exp op=%h rv=%0d done=%0d",
                         c, aluOpcode, resultValid, done, (c <= 2) ? 4'h7 : 4'h0,
                         (c == 3 || c == 4), (c == 5));
            end
        end
        checks++;
        if (result !== 8'h66) begin
            errors++;
            $display("[TB] FAIL same_cycle_result got %h exp 66", result);
        end
    endtask

    task automatic test_reset_mid_run;
        stubOut = 8'h99;
        writeWord(4'd0, 12'h122);
        pulseStart();
        tick();
        tick();
        checks++;
        if (aluOpcode !== 4'h7) begin
            errors++;
            $display("[TB] FAIL midrst_out got op=%h exp 7", aluOpcode);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, pc, aluOpcode, aluDataIn, result, resultValid} !== 27'd0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs got busy=%0d done=%0d pc=%0d op=%h din=%h res=%h rv=%0d exp all 0",
                     busy, done, pc, aluOpcode, aluDataIn, result, resultValid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (resultValid !== 1'b0 || result !== 8'h00 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_quiet c%0d got rv=%0d res=%h busy=%0d exp 0 00 0",
                         c, resultValid, result, busy);
            end
        end
        stubOut = 8'h5B;
        pulseStart();
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (aluOpcode !== ((c == 1) ? 4'h1 : (c == 2) ? 4'h7 : 4'h0) ||
                aluDataIn !== ((c == 1) ? 8'h22 : 8'h00) ||
                resultValid !== (c == 4) || done !== (c == 5)) begin
                errors++;
                $display("[TB] FAIL rerun E%0d got op=%h din=%h rv=%0d done=%0d",
                         c, aluOpcode, aluDataIn, resultValid, done);
            end
        end
        checks++;
        if (result !== 8'h5B) begin
            errors++;
            $display("[TB] FAIL rerun_result got %h exp 5b", result);
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_alu_program();
        test_full_program();
        test_handshake_guards();
        test_start_with_write();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
